// File: rtl/avr_hvpp_responder.sv
// AVR high-voltage parallel programming target model: synchronized strobes, load registers,
// 32x16 flash array, signature readout. Chip erase is built only with HVPP_RESPONDER_ERASE_EN.
module avr_hvpp_responder #(
    parameter int         BUSY_CYCLES = 16,
    parameter logic [7:0] SIG0        = 8'h1E,
    parameter logic [7:0] SIG1        = 8'h91,
    parameter logic [7:0] SIG2        = 8'h09
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       xtal,
    input  logic       xa0,
    input  logic       xa1,
    input  logic       bs1,
    input  logic       wr_n,
    input  logic       oe_n,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       rdy
);

    localparam int CNT_W = $clog2(BUSY_CYCLES + 32);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1
`ifdef HVPP_RESPONDER_ERASE_EN
        ,
        ST_ERASE = 2'd2
`endif
    } state_t;

    state_t     state_r, state_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic       rdy_n;

    logic       xtal_s1_r, xtal_s2_r, xtal_prev_r, xtal_arm_r;
    logic       wr_s1_r, wr_s2_r, wr_prev_r, wr_arm_r;
    logic       oe_s1_r, oe_s2_r;
    logic [10:0] in_s1_r, in_s2_r;
    logic [1:0] settle_r;
    logic       settled_s;

    logic       xtal_rise_s, wr_fall_s;
    logic [1:0] xa_s;
    logic       bs1_s;
    logic [7:0] din_s;

    logic [7:0] addr_lo_r, addr_hi_r, data_lo_r, data_hi_r, cmd_r;
    logic [7:0] addr_lo_n, addr_hi_n, data_lo_n, data_hi_n, cmd_n;

    logic [15:0] mem_r [0:31];
    logic        mem_we_s;
    logic [4:0]  mem_waddr_s;
    logic [15:0] mem_wdata_s;
    logic [7:0]  rd_s;
    logic        unused_s;

    function automatic logic [7:0] sig_byte(input logic [7:0] addr);
        case (addr)
            8'd0:    sig_byte = SIG0;
            8'd1:    sig_byte = SIG1;
            8'd2:    sig_byte = SIG2;
            default: sig_byte = 8'hFF;
        endcase
    endfunction

    assign settled_s   = (settle_r == 2'd2);
    assign xtal_rise_s = xtal_s2_r & ~xtal_prev_r & xtal_arm_r;
    assign wr_fall_s   = ~wr_s2_r & wr_prev_r & wr_arm_r;
    assign xa_s        = in_s2_r[10:9];
    assign bs1_s       = in_s2_r[8];
    assign din_s       = in_s2_r[7:0];
    assign unused_s    = ^addr_hi_r;

    // Strobe synchronizers; a strobe arms only after its idle level is seen post-reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xtal_s1_r   <= 1'b0;
            xtal_s2_r   <= 1'b0;
            xtal_prev_r <= 1'b0;
            xtal_arm_r  <= 1'b0;
            wr_s1_r     <= 1'b1;
            wr_s2_r     <= 1'b1;
            wr_prev_r   <= 1'b1;
            wr_arm_r    <= 1'b0;
            oe_s1_r     <= 1'b1;
            oe_s2_r     <= 1'b1;
            in_s1_r     <= 11'd0;
            in_s2_r     <= 11'd0;
            settle_r    <= 2'd0;
        end else begin
            xtal_s1_r   <= xtal;
            xtal_s2_r   <= xtal_s1_r;
            xtal_prev_r <= xtal_s2_r;
            xtal_arm_r  <= xtal_arm_r | (settled_s & ~xtal_s2_r);
            wr_s1_r     <= wr_n;
            wr_s2_r     <= wr_s1_r;
            wr_prev_r   <= wr_s2_r;
            wr_arm_r    <= wr_arm_r | (settled_s & wr_s2_r);
            oe_s1_r     <= oe_n;
            oe_s2_r     <= oe_s1_r;
            in_s1_r     <= {xa1, xa0, bs1, data_in};
            in_s2_r     <= in_s1_r;
            if (!settled_s) begin
                settle_r <= settle_r + 2'd1;
            end
        end
    end

    // Load-register next values; the write path below sees these, so a same-cycle load wins.
    always_comb begin
        addr_lo_n = addr_lo_r;
        addr_hi_n = addr_hi_r;
        data_lo_n = data_lo_r;
        data_hi_n = data_hi_r;
        cmd_n     = cmd_r;
        if (xtal_rise_s) begin
            case (xa_s)
                2'b00: begin
                    if (bs1_s) begin
                        addr_hi_n = din_s;
                    end else begin
                        addr_lo_n = din_s;
                    end
                end
                2'b01: begin
                    if (bs1_s) begin
                        data_hi_n = din_s;
                    end else begin
                        data_lo_n = din_s;
                    end
                end
                2'b10:   cmd_n = din_s;
                default: cmd_n = cmd_r;
            endcase
        end else begin
            cmd_n = cmd_r;
        end
    end

    // Operation FSM next state, busy counter and array write port.
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r;
        rdy_n       = rdy;
        mem_we_s    = 1'b0;
        mem_waddr_s = 5'd0;
        mem_wdata_s = 16'h0000;
        case (state_r)
            ST_IDLE: begin
                if (wr_fall_s && (cmd_n == 8'h10)) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = addr_lo_n[4:0];
                    mem_wdata_s = {data_hi_n, data_lo_n};
                    state_n     = ST_WRITE;
                    cnt_n       = {CNT_W{1'b0}};
                    rdy_n       = 1'b0;
`ifdef HVPP_RESPONDER_ERASE_EN
                end else if (wr_fall_s && (cmd_n == 8'h80)) begin
                    state_n = ST_ERASE;
                    cnt_n   = {CNT_W{1'b0}};
                    rdy_n   = 1'b0;
`endif
                end else begin
                    rdy_n = 1'b1;
                end
            end
            ST_WRITE: begin
                if (cnt_r == CNT_W'(BUSY_CYCLES - 1)) begin
                    state_n = ST_IDLE;
                    cnt_n   = {CNT_W{1'b0}};
                    rdy_n   = 1'b1;
                end else begin
                    cnt_n = cnt_r + CNT_W'(1);
                end
            end
`ifdef HVPP_RESPONDER_ERASE_EN
            ST_ERASE: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = cnt_r[4:0];
                mem_wdata_s = 16'hFFFF;
                if (cnt_r == CNT_W'(31)) begin
                    state_n = ST_IDLE;
                    cnt_n   = {CNT_W{1'b0}};
                    rdy_n   = 1'b1;
                end else begin
                    cnt_n = cnt_r + CNT_W'(1);
                end
            end
`endif
            default: begin
                state_n = ST_IDLE;
                cnt_n   = {CNT_W{1'b0}};
                rdy_n   = 1'b1;
            end
        endcase
    end

    // Read mux: busy array reads as erased, otherwise the command picks the source.
    always_comb begin
        rd_s = 8'h00;
        if (state_r != ST_IDLE) begin
            rd_s = 8'hFF;
        end else begin
            case (cmd_r)
                8'h02:   rd_s = bs1_s ? mem_r[addr_lo_r[4:0]][15:8] : mem_r[addr_lo_r[4:0]][7:0];
                8'h08:   rd_s = sig_byte(addr_lo_r);
                default: rd_s = 8'h00;
            endcase
        end
    end

    // Control, load and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            rdy       <= 1'b1;
            addr_lo_r <= 8'h00;
            addr_hi_r <= 8'h00;
            data_lo_r <= 8'h00;
            data_hi_r <= 8'h00;
            cmd_r     <= 8'h00;
            data_out  <= 8'h00;
            data_oe   <= 1'b0;
        end else begin
            state_r   <= state_n;
            cnt_r     <= cnt_n;
            rdy       <= rdy_n;
            addr_lo_r <= addr_lo_n;
            addr_hi_r <= addr_hi_n;
            data_lo_r <= data_lo_n;
            data_hi_r <= data_hi_n;
            cmd_r     <= cmd_n;
            if (!oe_s2_r) begin
                data_oe  <= 1'b1;
                data_out <= rd_s;
            end else begin
                data_oe  <= 1'b0;
                data_out <= 8'h00;
            end
        end
    end

    // Flash array is deliberately outside reset so contents survive it.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

endmodule

// File: doc/avr_hvpp_responder.md
AVR_HVPP_RESPONDER -- requirements
Module: avr_hvpp_responder

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 16, clk cycles rdy stays low after a flash write strobe.
REQ-002 SHALL have parameter SIG0/SIG1/SIG2, default 8'h1E/8'h91/8'h09, signature bytes returned for addresses 0/1/2.
REQ-003 SHALL have port clk  input  1  single clock; all state is in this domain.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port xtal  input  1  programmer's XTAL1 strobe; a rising edge performs a load action.
REQ-006 SHALL have ports xa0, xa1  input  1 each  load-action select.
REQ-007 SHALL have port bs1  input  1  byte select: 0 = low byte, 1 = high byte.
REQ-008 SHALL have port wr_n  input  1  write strobe; a falling edge starts a write or erase.
REQ-009 SHALL have port oe_n  input  1  output enable, active low.
REQ-010 SHALL have port data_in  input  8  programmer-driven data bus.
REQ-011 SHALL have port data_out  output  8  responder read data.
REQ-012 SHALL have port data_oe  output  1  tristate enable for data_out.
REQ-013 SHALL have port rdy  output  1  RDY/BSY pin: 1 = ready.

Function
REQ-014 SHALL pass xtal, wr_n and oe_n through 2-flop synchronizers plus an edge register; an action fires 3 clk cycles after the pin edge.
REQ-015 SHALL sample xa0, xa1, bs1 and data_in through the same 2-flop delay, so that they align with the strobes.
REQ-016 On xtal rise, SHALL act on {xa1,xa0}:
- 00 → load address byte (bs1 selects addr_lo or addr_hi).
- 01 → load data byte (bs1 selects data_lo or data_hi).
- 10 → load cmd.
- 11 → no action.
REQ-017 SHALL hold memory as 32 words x 16 bits, indexed by addr_lo[4:0]; addr_lo[7:5] and addr_hi SHALL be stored but ignored for indexing.
REQ-018 SHALL implement the FSM states IDLE, WRITE, ERASE.
REQ-019 In IDLE with cmd==8'h10 and a wr_n fall, SHALL write {data_hi,data_lo} to mem[addr_lo[4:0]], enter WRITE, and drop rdy on the next cycle.
REQ-020 WRITE SHALL count BUSY_CYCLES clocks, then return to IDLE with rdy=1.
REQ-021 A wr_n fall with any cmd other than 8'h10 or 8'h80 SHALL be ignored.
REQ-022 A wr_n fall in WRITE or ERASE SHALL be ignored.
REQ-023 xtal loads SHALL be accepted in every state and SHALL NOT disturb an operation already in progress.
REQ-024 If an xtal rise and a wr_n fall fire in the same cycle, the load SHALL apply first and the write SHALL use the newly loaded values.
REQ-025 When oe_n is low (synchronized), data_oe SHALL be 1 and data_out SHALL be:
- cmd 8'h02 → mem word byte selected by bs1.
- cmd 8'h08 → SIGn for addr_lo 0..2, else 8'hFF.
- otherwise → 8'h00.
REQ-026 data_out SHALL be registered and SHALL follow bs1 and address changes while oe_n stays low.
REQ-027 data_oe SHALL fall 3 cycles after oe_n rises.
REQ-028 If oe_n is low during WRITE or ERASE, SHALL drive data_out=8'hFF.

Reset
REQ-029 Asserting rst_n low SHALL immediately force IDLE, rdy=1, data_oe=0, data_out=0, cmd/addr/data registers=0, busy counter=0, and synchronizers to idle levels (xtal=0, wr_n=1, oe_n=1).
REQ-030 Reset SHALL NOT clear memory; a write or erase interrupted by reset SHALL leave memory partially updated, with no further change after reset.
REQ-031 The first action after reset release SHALL require a fresh edge; levels held through reset SHALL NOT fire.

Configuration
REQ-032 With HVPP_RESPONDER_ERASE_EN defined, SHALL apply chip erase: cmd==8'h80 plus a wr_n fall in IDLE enters ERASE, writes 16'hFFFF to one word per cycle for words 0..31, then returns to IDLE; rdy SHALL be low for exactly 32 cycles.
REQ-033 Without HVPP_RESPONDER_ERASE_EN, cmd 8'h80 SHALL be treated as unknown (wr_n ignored, rdy stays 1), and the ERASE state SHALL be absent.

Verification
REQ-034 Reset, then cmd 8'h08, addr_lo 1, oe_n low → data_out=8'h91, data_oe=1 within 3 cycles.
REQ-035 cmd 8'h10, addr_lo 5, data 8'h34/8'h12, wr_n pulse → rdy low for 16 cycles; then cmd 8'h02, bs1=1, oe_n low → 8'h12; bs1=0 → 8'h34.
REQ-036 Second wr_n fall issued 4 cycles into WRITE → no extra busy period, memory unchanged by the second strobe.
REQ-037 (ERASE_EN) After REQ-035, cmd 8'h80 plus wr_n → rdy low 32 cycles; read word 5 → 8'hFF/8'hFF. Without the macro → rdy stays 1 and word 5 keeps 16'h1234.
REQ-038 Assert rst_n mid-WRITE → rdy=1 and data_oe=0 at once; after release, held wr_n=0 produces no write.
REQ-039 xtal rise and wr_n fall in the same synchronized cycle, loading data_lo 8'hAA → stored word shows 8'hAA.
